load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the data path.
- Consumes the ALU-computed effective address, the rt store data and the load/store control, and drives the byte-laned data memory (4 x 8-bit lanes, big-endian).
- Returns the aligned, extended load value for the register-file writeback mux.
- Holds the core stalled through a variable-latency memory handshake.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- TIMEOUT_CYCLES, 64, memory wait limit; used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  access request from the data path
- req_load  in  1  1 = load, 0 = store
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend loads (lbu/lhu)
- req_addr  in  XLEN  effective byte address
- req_wdata  in  XLEN  store data (rt)
- busy  out  1  stall to the core
- done  out  1  one-cycle completion pulse
- load_data  out  XLEN  extended load result
- error  out  1  misaligned/illegal (or timeout) flag, valid with done
- mem_addr  out  XLEN  word address, bits [1:0] forced to 00
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_byte_en  out  4  lane enables; bit i = lane i
- mem_data_in  out  8 x [0:3]  store lanes; lane 0 = bits 31:24
- mem_data_out  in  8 x [0:3]  load lanes
- mem_ready  in  1  memory completes the request this cycle

Behaviour:
- Reset (asynchronous): state IDLE; every output 0; internal registers 0. Reset mid-ACCESS drops mem_req immediately, and the access is lost.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, req_valid=1, aligned and legal: latch request fields; go to ACCESS next edge.
- IDLE, req_valid=1, misaligned or size=11: go to RESP with error=1; no mem_req is ever issued.
- Alignment rules: half needs addr[0]=0; word needs addr[1:0]=00.
- ACCESS: mem_req=1; mem_addr, mem_we, mem_byte_en and mem_data_in stay stable until mem_ready. On a mem_ready edge, capture the load lanes and go to RESP. mem_ready sampled while mem_req=0 is ignored.
- RESP: done=1 for exactly one cycle; return to IDLE. req_valid is ignored in RESP.
- busy = (IDLE and req_valid) or ACCESS. busy is low in RESP, so the core advances at the end of the done cycle.
- Minimum latency: accept in cycle N, mem_ready in N+1, done in N+2.
- Byte lane = addr[1:0]. Half lanes: {0,1} for addr[1]=0, {2,3} for addr[1]=1.
- Store byte enables: byte gives a one-hot enable; half gives 1100 or 0011; word gives 1111.
- Store data is replicated: byte wdata[7:0] goes to all four lanes; half wdata[15:0] goes to both lane pairs; word wdata[31:0] maps wdata[31:24] to lane 0.
- Load: select the lanes from addr[1:0]; sign-extend unless req_unsigned; for a word load, req_unsigned is ignored.
- load_data updates only on the done cycle and holds until the next done.
- Store completion: load_data is unchanged.
- error=1 only on the done cycle of a failing access.

Optional Feature:
- LSU_TIMEOUT_EN defined: a counter runs in ACCESS. If mem_ready has not arrived after TIMEOUT_CYCLES cycles, drop mem_req, go to RESP with error=1, and leave load_data unchanged.
- LSU_TIMEOUT_EN undefined: no counter; ACCESS waits for mem_ready indefinitely.

Decomposition:
- Shared package lsu_pkg:
  - size encoding constants SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum lsu_state_t
  - function is_aligned(size, addr[1:0])
- One sub-module, lsu_lane_align (combinational). It contains the store lane replication and byte-enable generation, plus the load lane select and extension. It is unit-testable on its own.

Test Plan:
- sw with addr=0x100, wdata=0xDEADBEEF, mem_ready 1 cycle after mem_req -> mem_byte_en=1111, lanes DE,AD,BE,EF, mem_addr=0x100, done at N+2, error=0.
- lb with addr=0x203, lane 3=0x80, signed -> load_data=0xFFFFFF80; same access with lbu -> 0x00000080.
- sh with addr=0x12, wdata=0x0000A55A -> mem_byte_en=0011, mem_addr=0x10, lanes 2,3 = A5,5A; lh back from addr 0x12 -> 0xFFFFA55A.
- lw with addr=0x101 -> no mem_req, done the next cycle with error=1, load_data held.
- lw with mem_ready delayed 5 cycles -> busy stays high and outputs stay stable throughout; assert reset in the 3rd wait cycle -> mem_req, busy and done are 0 immediately; the next request proceeds normally.
- With LSU_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, mem_ready never asserted -> done with error=1 after 8 ACCESS cycles.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared size encodings, FSM state type and alignment rule for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    // Size 2'b11 is illegal and therefore never aligned.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: is_aligned = 1'b1;
            SZ_HALF: is_aligned = ~addr_lo[0];
            SZ_WORD: is_aligned = (addr_lo == 2'b00);
            default: is_aligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering between the 32-bit datapath and the big-endian 4 x 8-bit memory lanes.
// Lane 0 carries bits 31:24; byte_en_o[i] enables lane i.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]      size_i,
    input  logic [1:0]      addr_lo_i,
    input  logic            unsigned_i,
    input  logic [31:0]     wdata_i,
    input  logic [0:3][7:0] lanes_i,
    output logic [0:3]      byte_en_o,
    output logic [0:3][7:0] lanes_o,
    output logic [31:0]     load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store data is replicated across lanes so only the enables depend on the address.
    always_comb begin
        byte_en_o = '0;
        lanes_o   = '0;
        case (size_i)
            SZ_BYTE: begin
                byte_en_o[addr_lo_i] = 1'b1;
                lanes_o              = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                byte_en_o = addr_lo_i[1] ? 4'b0011 : 4'b1100;
                lanes_o   = {2{wdata_i[15:0]}};
            end
            SZ_WORD: begin
                byte_en_o = 4'b1111;
                lanes_o   = wdata_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_sel = lanes_i[addr_lo_i];
        half_sel = addr_lo_i[1] ? {lanes_i[2], lanes_i[3]} : {lanes_i[0], lanes_i[1]};
        case (size_i)
            SZ_BYTE: load_data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
            SZ_HALF: load_data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
            default: load_data_o = lanes_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE -> ACCESS -> RESP memory stage with a variable-latency ready handshake.
// Defining LSU_TIMEOUT_EN bounds the ACCESS wait to TIMEOUT_CYCLES cycles.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic            req_load,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] load_data,
    output logic            error,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_req,
    output logic            mem_we,
    output logic [0:3]      mem_byte_en,
    output logic [0:3][7:0] mem_data_in,
    input  logic [0:3][7:0] mem_data_out,
    input  logic            mem_ready
);

    lsu_state_t      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    logic [1:0]      size_q, size_d;
    logic            load_q, load_d;
    logic            unsigned_q, unsigned_d;
    logic            err_q, err_d;
    logic            in_access;
    logic            timed_out;
    logic [0:3]      lane_be;
    logic [0:3][7:0] lane_wdata;
    logic [XLEN-1:0] lane_load;

    assign in_access = (state_q == ACCESS);

    lsu_lane_align u_align (
        .size_i      (size_q),
        .addr_lo_i   (addr_q[1:0]),
        .unsigned_i  (unsigned_q),
        .wdata_i     (wdata_q),
        .lanes_i     (mem_data_out),
        .byte_en_o   (lane_be),
        .lanes_o     (lane_wdata),
        .load_data_o (lane_load)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] tmo_q, tmo_d;

    assign tmo_d     = in_access ? tmo_q + TW'(1) : '0;
    assign timed_out = in_access && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        load_d      = load_q;
        unsigned_d  = unsigned_q;
        err_d       = err_q;
        load_data_d = load_data_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (is_aligned(req_size, req_addr[1:0])) begin
                        addr_d     = req_addr;
                        wdata_d    = req_wdata;
                        size_d     = req_size;
                        load_d     = req_load;
                        unsigned_d = req_unsigned;
                        err_d      = 1'b0;
                        state_d    = ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            // The extended value is registered here so it appears together with done.
            ACCESS: begin
                if (mem_ready) begin
                    err_d   = 1'b0;
                    state_d = RESP;
                    if (load_q) load_data_d = lane_load;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            load_q      <= 1'b0;
            unsigned_q  <= 1'b0;
            err_q       <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            load_q      <= load_d;
            unsigned_q  <= unsigned_d;
            err_q       <= err_d;
            load_data_q <= load_data_d;
        end
    end

    // Memory-side outputs derive from state so an async reset drops them at once.
    assign mem_req     = in_access;
    assign mem_we      = in_access & ~load_q;
    assign mem_addr    = in_access ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign mem_byte_en = in_access ? lane_be : '0;
    assign mem_data_in = (in_access && !load_q) ? lane_wdata : '0;

    assign busy      = (state_q == IDLE && req_valid) || in_access;
    assign done      = (state_q == RESP);
    assign error     = done & err_q;
    assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized accesses
// checked against a byte-array memory model. Define LSU_TIMEOUT_EN to exercise the timeout.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int TMO = 8;

    logic            clk;
    logic            reset;
    logic            reqValid;
    logic            reqLoad;
    logic [1:0]      reqSize;
    logic            reqUnsigned;
    logic [31:0]     reqAddr;
    logic [31:0]     reqWdata;
    logic            busy;
    logic            done;
    logic [31:0]     loadData;
    logic            error;
    logic [31:0]     memAddr;
    logic            memReq;
    logic            memWe;
    logic [0:3]      memByteEn;
    logic [0:3][7:0] memDataIn;
    logic [0:3][7:0] memDataOut;
    logic            memReady;

    logic [7:0]  devMem [0:255];
    logic [7:0]  refMem [0:255];
    logic        memInit = 1'b0;
    logic [31:0] refLoadData;
    int          checks = 0;
    int          errors = 0;

    load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (reqValid),
        .req_load     (reqLoad),
        .req_size     (reqSize),
        .req_unsigned (reqUnsigned),
        .req_addr     (reqAddr),
        .req_wdata    (reqWdata),
        .busy         (busy),
        .done         (done),
        .load_data    (loadData),
        .error        (error),
        .mem_addr     (memAddr),
        .mem_req      (memReq),
        .mem_we       (memWe),
        .mem_byte_en  (memByteEn),
        .mem_data_in  (memDataIn),
        .mem_data_out (memDataOut),
        .mem_ready    (memReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory device: the only writer of devMem; applies enabled lanes on a ready edge.
    always @(posedge clk) begin
        if (!memInit) begin
            for (int i = 0; i < 256; i++) devMem[i] <= 8'(i * 37 + 5);
            memInit <= 1'b1;
        end else if (memReq && memReady && memWe) begin
            for (int l = 0; l < 4; l++)
                if (memByteEn[l]) devMem[{memAddr[7:2], 2'(l)}] <= memDataIn[l];
        end
    end

    always @* begin
        for (int l = 0; l < 4; l++) memDataOut[l] = devMem[{memAddr[7:2], 2'(l)}];
    end

    // Reference model: memory as bytes, big-endian values assembled arithmetically.
    function automatic logic refIsLegal(input logic [31:0] addr, input logic [1:0] size);
        if (size == 2'b11) return 1'b0;
        return (addr & ((32'd1 << size) - 32'd1)) == 32'd0;
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] addr, input logic [1:0] size, input logic unsgn);
        int n;
        logic [31:0] v;
        n = 1 << size;
        v = '0;
        for (int j = 0; j < n; j++) v = (v << 8) | 32'(refMem[8'(addr + 32'(j))]);
        if (!unsgn && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    function automatic void refStore(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
        int n;
        n = 1 << size;
        for (int j = 0; j < n; j++) refMem[8'(addr + 32'(j))] = 8'(wdata >> (8 * (n - 1 - j)));
    endfunction

    function automatic logic [0:3] refByteEn(input logic [31:0] addr, input logic [1:0] size);
        int n, first;
        logic [0:3] be;
        n = 1 << size;
        first = int'(addr % 32'd4);
        for (int l = 0; l < 4; l++) be[l] = (l >= first) && (l < first + n);
        return be;
    endfunction

    function automatic logic [31:0] refStoreLanes(input logic [31:0] wdata, input logic [1:0] size);
        int n;
        logic [31:0] r;
        n = 1 << size;
        r = '0;
        for (int l = 0; l < 4; l++) r[31 - 8 * l -: 8] = 8'(wdata >> (8 * (n - 1 - (l % n))));
        return r;
    endfunction

    function automatic logic [31:0] devWord(input logic [31:0] addr);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < 4; j++) w = (w << 8) | 32'(devMem[{addr[7:2], 2'(j)}]);
        return w;
    endfunction

    function automatic logic [31:0] refWord(input logic [31:0] addr);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < 4; j++) w = (w << 8) | 32'(refMem[{addr[7:2], 2'(j)}]);
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One complete access, checked cycle by cycle against the model.
    task automatic applyStimulus(input logic isLoad, input logic [1:0] size, input logic unsgn,
                                 input logic [31:0] addr, input logic [31:0] wdata, input int readyDelay,
                                 output int latency, output logic [31:0] dataSeen, output logic reqSeen,
                                 output logic [0:3] beSeen, output logic [31:0] lanesSeen,
                                 output logic [31:0] addrSeen);
        int   waitCnt;
        int   expLatency;
        logic legal;
        logic timesOut;
        logic expErr;
        legal    = refIsLegal(addr, size);
        timesOut = 1'b0;
`ifdef LSU_TIMEOUT_EN
        timesOut = legal && (readyDelay >= TMO);
`endif
        expErr     = !legal || timesOut;
        expLatency = !legal ? 1 : (timesOut ? TMO + 1 : readyDelay + 2);
        if (legal && isLoad && !timesOut) refLoadData = refLoad(addr, size, unsgn);

        @(negedge clk);
        reqValid    = 1'b1;
        reqLoad     = isLoad;
        reqSize     = size;
        reqUnsigned = unsgn;
        reqAddr     = addr;
        reqWdata    = wdata;
        #1 checkOutput("busy on request", 32'(busy), 32'd1);
        @(negedge clk);
        reqValid    = 1'b0;
        reqAddr     = $urandom();
        reqWdata    = $urandom();
        reqSize     = 2'($urandom_range(0, 3));
        reqLoad     = 1'($urandom_range(0, 1));
        latency     = 1;
        waitCnt     = 0;
        reqSeen     = 1'b0;
        beSeen      = '0;
        lanesSeen   = '0;
        addrSeen    = '0;
        while (!done && latency < 100) begin
            if (memReq) begin
                if (!reqSeen) begin
                    reqSeen   = 1'b1;
                    beSeen    = memByteEn;
                    lanesSeen = memDataIn;
                    addrSeen  = memAddr;
                end
                checkOutput("busy in access", 32'(busy), 32'd1);
                checkOutput("mem_addr", memAddr, {addr[31:2], 2'b00});
                checkOutput("mem_we", 32'(memWe), 32'(!isLoad));
                if (!isLoad) begin
                    checkOutput("mem_byte_en", 32'(memByteEn), 32'(refByteEn(addr, size)));
                    checkOutput("mem_data_in", memDataIn, refStoreLanes(wdata, size));
                end
                memReady = (waitCnt == readyDelay);
                waitCnt++;
            end
            @(negedge clk);
            memReady = 1'b0;
            latency++;
        end
        checkOutput("done pulse", 32'(done), 32'd1);
        checkOutput("latency", 32'(latency), 32'(expLatency));
        checkOutput("error on done", 32'(error), 32'(expErr));
        checkOutput("busy in resp", 32'(busy), 32'd0);
        checkOutput("mem_req in resp", 32'(memReq), 32'd0);
        checkOutput("load_data at done", loadData, refLoadData);
        checkOutput("mem_req issued", 32'(reqSeen), 32'(legal));
        dataSeen = loadData;
        @(negedge clk);
        checkOutput("done one cycle", 32'(done), 32'd0);
        checkOutput("error cleared", 32'(error), 32'd0);
        checkOutput("load_data held", loadData, refLoadData);
        if (legal && !isLoad && !timesOut) begin
            refStore(addr, size, wdata);
            checkOutput("memory word", devWord(addr), refWord(addr));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        logic [31:0] dSeen;
        logic        rSeen;
        logic [0:3]  bSeen;
        logic [31:0] lSeen;
        logic [31:0] aSeen;
        logic        rLoad;
        logic [1:0]  rSize;
        logic [31:0] rAddr;

        reset       = 1'b1;
        reqValid    = 1'b0;
        reqLoad     = 1'b0;
        reqSize     = 2'b00;
        reqUnsigned = 1'b0;
        reqAddr     = '0;
        reqWdata    = '0;
        memReady    = 1'b0;
        refLoadData = '0;
        for (int i = 0; i < 256; i++) refMem[i] = 8'(i * 37 + 5);
        repeat (3) @(negedge clk);

        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset error", 32'(error), 32'd0);
        checkOutput("reset load_data", loadData, 32'd0);
        checkOutput("reset mem_req", 32'(memReq), 32'd0);
        checkOutput("reset mem_we", 32'(memWe), 32'd0);
        checkOutput("reset mem_addr", memAddr, 32'd0);
        checkOutput("reset mem_byte_en", 32'(memByteEn), 32'd0);
        checkOutput("reset mem_data_in", memDataIn, 32'd0);
        reset = 1'b0;

        $display("[TB] sw 0x100");
        applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 0, lat, dSeen, rSeen, bSeen, lSeen, aSeen);
        checkOutput("sw byte_en", 32'(bSeen), 32'h0000000F);
        checkOutput("sw lanes", lSeen, 32'hDEADBEEF);
        checkOutput("sw mem_addr", aSeen, 32'h100);
        checkOutput("sw latency", 32'(lat), 32'd2);

        $display("[TB] sb/lb/lbu 0x203");
        applyStimulus(1'b0, SZ_BYTE, 1'b0, 32'h203, 32'h12345680, 1, lat, dSeen, rSeen, bSeen, lSeen, aSeen);
        checkOutput("sb byte_en", 32'(bSeen), 32'h00000001);
        applyStimulus(1'b1, SZ_BYTE, 1'b0, 32'h203, 32'h0, 0, lat, dSeen, rSeen, bSeen, lSeen, aSeen);
        checkOutput("lb signed", dSeen, 32'hFFFFFF80);
        applyStimulus(1'b1, SZ_BYTE, 1'b1, 32'h203, 32'h0, 2, lat, dSeen, rSeen, bSeen, lSeen, aSeen);
        checkOutput("lbu unsigned", dSeen, 32'h00000080);

        $display("[TB] sh/lh 0x12");
        applyStimulus(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0000A55A, 0, lat, dSeen, rSeen, bSeen, lSeen, aSeen);
        checkOutput("sh byte_en", 32'(bSeen), 32'h00000003);
        checkOutput("sh mem_addr", aSeen, 32'h10);
        checkOutput("sh lanes 2,3", {16'h0, lSeen[15:0]}, 32'h0000A55A);
        applyStimulus(1'b1, SZ_HALF, 1'b0, 32'h12, 32'h0, 0, lat, dSeen, rSeen, bSeen, lSeen, aSeen);
        checkOutput("lh signed", dSeen, 32'hFFFFA55A);

        $display("[TB] misaligned and illegal");
        applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h101, 32'h0, 0, lat, dSeen, rSeen, bSeen, lSeen, aSeen);
        checkOutput("lw misaligned no req", 32'(rSeen), 32'd0);
        checkOutput("lw misaligned latency", 32'(lat), 32'd1);
        checkOutput("lw misaligned data held", dSeen, 32'hFFFFA55A);
        applyStimulus(1'b0, SZ_HALF, 1'b0, 32'h33, 32'h1234, 0, lat, dSeen, rSeen, bSeen, lSeen, aSeen);
        applyStimulus(1'b1, 2'b11, 1'b0, 32'h40, 32'h0, 0, lat, dSeen, rSeen, bSeen, lSeen, aSeen);

        $display("[TB] mem_ready while idle");
        @(negedge clk);
        memReady = 1'b1;
        #1 checkOutput("idle mem_req", 32'(memReq), 32'd0);
        @(negedge clk);
        checkOutput("idle ready ignored done", 32'(done), 32'd0);
        checkOutput("idle ready ignored busy", 32'(busy), 32'd0);
        memReady = 1'b0;

        $display("[TB] delayed ready then reset mid-access");
        applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h44, 32'h0, 5, lat, dSeen, rSeen, bSeen, lSeen, aSeen);
        checkOutput("lw delay5 latency", 32'(lat), 32'd7);
        @(negedge clk);
        reqValid = 1'b1;
        reqLoad  = 1'b1;
        reqSize  = SZ_WORD;
        reqAddr  = 32'h48;
        @(negedge clk);
        reqValid = 1'b0;
        checkOutput("pre-reset mem_req", 32'(memReq), 32'd1);
        @(negedge clk);
        checkOutput("pre-reset busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("reset drops mem_req", 32'(memReq), 32'd0);
        checkOutput("reset drops busy", 32'(busy), 32'd0);
        checkOutput("reset drops done", 32'(done), 32'd0);
        checkOutput("reset clears load_data", loadData, 32'd0);
        refLoadData = '0;
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h48, 32'h0, 1, lat, dSeen, rSeen, bSeen, lSeen, aSeen);
        checkOutput("post-reset latency", 32'(lat), 32'd3);

`ifdef LSU_TIMEOUT_EN
        $display("[TB] timeout with no mem_ready");
        applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h80, 32'h0, 1000, lat, dSeen, rSeen, bSeen, lSeen, aSeen);
        checkOutput("timeout latency", 32'(lat), 32'(TMO + 1));
`else
        $display("[TB] long wait without timeout");
        applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h80, 32'h0, 20, lat, dSeen, rSeen, bSeen, lSeen, aSeen);
        checkOutput("long wait latency", 32'(lat), 32'd22);
`endif

        $display("[TB] randomized accesses");
        for (int k = 0; k < 60; k++) begin
            rLoad = 1'($urandom_range(0, 1));
            rSize = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            rAddr = ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 255));
            if (rSize != 2'b11 && $urandom_range(0, 9) < 7) rAddr = rAddr & ~((32'd1 << rSize) - 32'd1);
            applyStimulus(rLoad, rSize, 1'($urandom_range(0, 1)), rAddr, $urandom(),
                          int'($urandom_range(0, 4)), lat, dSeen, rSeen, bSeen, lSeen, aSeen);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
